seq_bin2bcd: RTL and testbench
==============================

Name: seq_bin2bcd

Overview:
Multi-cycle binary-to-packed-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits between the CPU register outputs (AX/DX, zero-extended) and the seven-segment display driver, and supplies the packed BCD digit word that the display scans. It trades the large combinational converter for a small iterative datapath, and holds the last result stable for the display while the next conversion runs.

Parameters:
W, 16, binary input width in bits; legal range 1..32.
DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^W-1. An illegal combination must fail elaboration.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
start  input  1  request a conversion of bin; sampled only in IDLE.
auto  input  1  free-running mode; in IDLE, a high level acts as start.
bin  input  W  binary operand; captured on the accepting edge only.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd is updated.
bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].

Behaviour:
- Reset (RESET high at a rising edge): state=IDLE, busy=0, done=0, bcd=0, internal shift and scratch registers=0, counter=0. Reset overrides every other input, including mid-conversion. An aborted conversion never updates bcd and never pulses done.
- States: IDLE, CONV.
- IDLE, with (start|auto)=1 at edge k:
  - shift register <= bin; BCD scratch <= 0; counter <= 0; state <= CONV.
  - busy is 1 from after edge k.
- IDLE, otherwise: hold state; done <= 0.
- CONV, each edge:
  - Every scratch digit >= 5 has 3 added (4-bit add, no carry between digits).
  - Then {scratch, shift} is shifted left by 1 as one concatenated register. The MSB of shift enters bit 0 of scratch.
  - counter increments.
- CONV, on the edge where counter==W-1:
  - bcd <= the adjusted-and-shifted scratch value; done <= 1; state <= IDLE; busy <= 0.
- Latency: start accepted at edge k gives the result on bcd and done=1 after edge k+W. busy is high for exactly W cycles.
- done is a single-cycle pulse. It is cleared on the next edge unless a new completion occurs on that edge. Completion is never possible on consecutive edges when W>1. With W=1, back-to-back conversions pulse done every other cycle.
- Back-to-back: start/auto high in the cycle where done=1 (state IDLE) is accepted. The throughput is therefore one conversion per W+1 cycles.
- start asserted during CONV is ignored, not queued. A change in bin during CONV does not affect the running conversion.
- bcd changes only on a completion edge or on reset. The display never sees intermediate scratch values.
- Counter width: ceil(log2(W))+1 bits. No wrap occurs because the counter resets on every accept.
- The scratch width is 4*DIGITS. Given the parameter constraint, the adjusted digits never overflow and the upper bits shifted out are always 0.

Test Plan:
1. W=16, DIGITS=5, RESET for 2 cycles -> bcd=0x00000, busy=0, done=0.
2. start pulse with bin=16'd255 at edge k -> busy is high for 16 cycles; after edge k+16, bcd=20'h00255 and done=1 for exactly one cycle.
3. bin=16'd65535 -> bcd=20'h65535. bin=16'd0 -> bcd=20'h00000. bin=16'd10009 -> bcd=20'h10009.
4. start with bin=16'd42, then bin changed to 16'd99 and start re-pulsed mid-conversion -> the result is 20'h00042, and no second conversion follows.
5. RESET asserted at cycle 8 of a conversion of 16'd1234 -> bcd stays 0, done never pulses, state returns to IDLE. A subsequent start with 16'd1234 yields 20'h01234.
6. auto=1 held, with bin stepping 7 -> 8 -> 9 one value per 17 cycles -> done pulses every 17 cycles, and bcd tracks 20'h00007, 20'h00008, 20'h00009.

Source files
------------

// File: rtl/seq_bin2bcd.sv
// Iterative binary-to-packed-BCD converter (shift-and-add-3), one input bit per clock.
// bcd holds the last completed result while the next conversion runs.
module seq_bin2bcd #(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  auto,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(W) + 1;
    localparam int SW = 4 * DIGITS;

    function automatic bit params_ok();
        longint unsigned max_val;
        longint unsigned p;
        if (W < 1 || W > 32 || DIGITS < 1) return 1'b0;
        max_val = (64'd1 << W) - 64'd1;
        p = 64'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (p <= max_val) p = p * 64'd10;
        end
        return p > max_val;
    endfunction

    localparam bit PARAMS_OK = params_ok();

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("seq_bin2bcd: W must be 1..32 and 10**DIGITS must exceed 2**W-1");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t          state;
    logic [W-1:0]    shift_q;
    logic [SW-1:0]   scratch;
    logic [CW-1:0]   cnt;

    logic [SW-1:0]   adj;
    logic [SW-1:0]   scratch_next;

    // Digit adjust then one-bit shift of {scratch, shift_q}; the top scratch bit is always 0 here.
    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        scratch_next = (adj << 1) | {{(SW-1){1'b0}}, shift_q[W-1]};
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            shift_q <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || auto) begin
                        shift_q <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_q << 1;
                    scratch <= scratch_next;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        bcd   <= scratch_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed and randomized checks of seq_bin2bcd against a decimal-arithmetic reference.
module tb_seq_bin2bcd;

    localparam int W      = 16;
    localparam int DIGITS = 5;

    logic                  clk = 1'b0;
    logic                  RESET;
    logic                  start;
    logic                  auto;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    int total = 0;
    int bad   = 0;

    seq_bin2bcd #(.W(W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .RESET (RESET),
        .start (start),
        .auto  (auto),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at the next edge, then W edges of conversion; bin is scrambled mid-run.
    task automatic convert(input int unsigned v, input string tag);
        logic [4*DIGITS-1:0] held;
        held  = bcd;
        bin   = W'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
        for (int i = 1; i < W; i++) begin
            bin = W'($urandom);
            tick();
            if (busy !== 1'b1 || done !== 1'b0 || bcd !== held)
                chk({tag, "_midrun"}, {10'd0, busy, done, bcd}, {10'd0, 1'b1, 1'b0, held});
        end
        tick();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_bcd_hold"}, 32'(bcd), 32'(ref_bcd(v)));
    endtask

    initial begin
        int unsigned v;
        int cycles;
        int last_done;
        bit seen;
        logic [4*DIGITS-1:0] held;

        RESET = 1'b1; start = 1'b0; auto = 1'b0; bin = '0;
        tick(); tick();
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        RESET = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        convert(255, "d255");
        convert(65535, "d65535");
        convert(0, "d0");
        convert(10009, "d10009");

        for (int n = 0; n < 20; n++) begin
            v = $urandom_range(0, 65535);
            convert(v, "rand");
        end

        // start re-pulsed with new bin mid-conversion must be ignored
        bin = 16'd42; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bin = 16'd99; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("ignore_done_seen", 32'(seen), 32'd1);
        chk("ignore_bcd", 32'(bcd), 32'(ref_bcd(42)));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0)
                chk("ignore_no_second", {30'd0, busy, done}, 32'd0);
        end

        // reset mid-conversion aborts without touching bcd
        bin = 16'd1234; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("abort_bcd", 32'(bcd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0)
                chk("abort_idle", {10'd0, busy, done, bcd}, 32'd0);
        end
        convert(1234, "after_abort");

        // auto mode: one conversion per W+1 cycles, bin sampled on each accept
        bin = 16'd7; auto = 1'b1;
        cycles = 0;
        last_done = -1;
        for (int k = 7; k <= 9; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                cycles++;
                if (done === 1'b1) seen = 1'b1;
            end
            chk("auto_done_seen", 32'(seen), 32'd1);
            chk("auto_bcd", 32'(bcd), 32'(ref_bcd(k)));
            if (last_done >= 0) chk("auto_period", 32'(cycles - last_done), 32'd17);
            last_done = cycles;
            held = bcd;
            bin = W'(k + 1);
            if (k == 9) auto = 1'b0;
            else begin
                tick();
                cycles++;
                chk("auto_done_pulse", 32'(done), 32'd0);
                chk("auto_busy_restart", 32'(busy), 32'd1);
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || bcd !== held)
                chk("auto_stop", {10'd0, busy, done, bcd}, {12'd0, held});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
